bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, max consecutive m0 grants while m1 waits.
REQ-002 Parameter TIMEOUT, default 15, max ACCESS cycles before a forced error response.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mN_req  input  1  master N (N=0 CPU data port, N=1 secondary master) request; held until mN_ack.
REQ-006 mN_we  input  1  master N write enable.
REQ-007 mN_addr  input  32  master N byte address.
REQ-008 mN_wdata  input  32  master N write data.
REQ-009 mN_byteen  input  4  master N byte enables.
REQ-010 mN_ack  output  1  one-cycle completion pulse to master N.
REQ-011 mN_err  output  1  error flag, valid only with mN_ack.
REQ-012 mN_rdata  output  32  read data, valid only with mN_ack.
REQ-013 s_valid  output  1  slave access strobe.
REQ-014 s_we, s_addr, s_wdata, s_byteen  output  1/32/32/4  slave access fields.
REQ-015 s_ready  input  1  slave completion; s_rdata sampled the same cycle.
REQ-016 s_rdata  input  32  slave read data.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any req high, select winner, latch its we/addr/wdata/byteen, record owner; no req -> stay IDLE.
REQ-020 Selection: only one req -> that master; both -> m0 unless starve_cnt == STARVE_MAX, then m1.
REQ-021 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL increment when m0 wins with m1_req high, clear when m1 wins or when m0 wins with m1_req low.
REQ-022 Legal address: 0x0000_0000-0x0000_2FFF, 0x0000_7F00-0x0000_7F0B, 0x0000_7F10-0x0000_7F1B, 0x0000_7F20-0x0000_7F23; legal -> ACCESS; illegal -> RESP with err=1, rdata=0, no s_valid pulse.
REQ-023 ACCESS: s_valid=1 with latched fields; s_byteen = latched byteen if we else 4'b0.
REQ-024 ACCESS with s_ready=1: capture s_rdata (0 if we=1), err=0, go RESP.
REQ-025 ACCESS cycle counter SHALL clear on entering ACCESS and increment each ACCESS cycle without s_ready; on reaching TIMEOUT -> RESP, err=1, rdata=0.
REQ-026 s_ready in the same cycle the counter reaches TIMEOUT SHALL win (normal completion, err=0).
REQ-027 RESP: owner's ack=1 for exactly one cycle with registered rdata/err; non-owner ack=0; then IDLE.
REQ-028 Both mN_rdata/mN_err SHALL be driven from shared response registers; meaning only with own ack.
REQ-029 Latency: legal access with s_ready in first ACCESS cycle -> ack on 3rd edge after req sampled; illegal -> ack on 2nd edge.
REQ-030 Masters SHALL drop req the cycle after ack; arbiter samples req only in IDLE and ignores s_ready outside ACCESS.
REQ-031 Outside ACCESS: s_valid=0, s_byteen=0, s_addr/s_wdata/s_we hold latched values.
REQ-032 Requests changing while not IDLE SHALL not affect the in-flight transaction.

Reset
REQ-033 reset low SHALL immediately force IDLE, starve_cnt=0, counter=0, all outputs and latched fields 0, owner=m0.
REQ-034 Reset mid-ACCESS or mid-RESP SHALL abandon the transaction with no ack issued after release.

Verification
REQ-035 m0 read 0x0000_0100, s_ready first ACCESS cycle, s_rdata=0xDEAD_BEEF -> m0_ack on 3rd edge, m0_rdata=0xDEAD_BEEF, m0_err=0, s_byteen=0.
REQ-036 m1 write 0x0000_0200 byteen=4'b0011, wdata=0x1234_5678 -> s_we=1, s_byteen=4'b0011, s_wdata=0x1234_5678 during ACCESS, m1_ack err=0.
REQ-037 m0 and m1 requesting continuously -> grant order m0,m0,m0,m0,m1,m0,... (STARVE_MAX=4).
REQ-038 m0 read 0x0000_5000 -> no s_valid, m0_ack on 2nd edge, m0_err=1, m0_rdata=0.
REQ-039 s_ready held low -> s_valid high 15 cycles, then ack err=1; s_ready on 15th cycle -> err=0.
REQ-040 reset low during ACCESS -> s_valid=0 and busy=0 immediately, no ack after release, next request served normally.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master / one-slave bus bundle for bus_arbiter.
// The slave modport is the arbiter's view; master is the view of the agents around it.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_byteen;
    logic        s_ready;
    logic [31:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_byteen,
        output m1_ack, m1_err, m1_rdata,
        output s_valid, s_we, s_addr, s_wdata, s_byteen,
        input  s_ready, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_byteen,
        input  m1_ack, m1_err, m1_rdata,
        input  s_valid, s_we, s_addr, s_wdata, s_byteen,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter onto a single slave port with
// starvation guard for m1, address decode and access timeout.
module bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus,
    output logic           busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic          owner;
    logic [2:0]    starve_cnt;
    logic [TW-1:0] acc_cnt;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_byteen;

    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic          any_req;
    logic          grant_m1;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_byteen;
    logic          sel_legal;
    logic          timeout_hit;

    function automatic logic addr_legal(input logic [31:0] a);
        logic ok;
        ok = 1'b0;
        if (a <= 32'h0000_2FFF)
            ok = 1'b1;
        else if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B)
            ok = 1'b1;
        else if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1B)
            ok = 1'b1;
        else if (a >= 32'h0000_7F20 && a <= 32'h0000_7F23)
            ok = 1'b1;
        return ok;
    endfunction

    // m0 has priority unless m1 has already been passed over STARVE_MAX times.
    always_comb begin
        any_req  = bus.m0_req | bus.m1_req;
        grant_m1 = bus.m1_req & (~bus.m0_req | (starve_cnt == 3'(STARVE_MAX)));
    end

    always_comb begin
        sel_we     = bus.m0_we;
        sel_addr   = bus.m0_addr;
        sel_wdata  = bus.m0_wdata;
        sel_byteen = bus.m0_byteen;
        if (grant_m1) begin
            sel_we     = bus.m1_we;
            sel_addr   = bus.m1_addr;
            sel_wdata  = bus.m1_wdata;
            sel_byteen = bus.m1_byteen;
        end
    end

    assign sel_legal   = addr_legal(sel_addr);
    assign timeout_hit = (acc_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 3'd0;
            acc_cnt    <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_byteen <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_m1;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        lat_byteen <= sel_byteen;
                        acc_cnt    <= '0;
                        if (grant_m1 || !bus.m1_req)
                            starve_cnt <= 3'd0;
                        else if (starve_cnt != 3'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 3'd1;
                        if (sel_legal) begin
                            state <= ACCESS;
                        end else begin
                            state      <= RESP;
                            resp_rdata <= 32'd0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // A completion in the timeout cycle still counts as a normal one.
                    if (bus.s_ready) begin
                        state      <= RESP;
                        resp_rdata <= lat_we ? 32'd0 : bus.s_rdata;
                        resp_err   <= 1'b0;
                    end else begin
                        acc_cnt <= acc_cnt + TW'(1);
                        if (timeout_hit) begin
                            state      <= RESP;
                            resp_rdata <= 32'd0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        bus.s_valid  = (state == ACCESS);
        bus.s_we     = lat_we;
        bus.s_addr   = lat_addr;
        bus.s_wdata  = lat_wdata;
        bus.s_byteen = ((state == ACCESS) && lat_we) ? lat_byteen : 4'd0;
        bus.m0_ack   = (state == RESP) && !owner;
        bus.m1_ack   = (state == RESP) && owner;
        bus.m0_rdata = resp_rdata;
        bus.m1_rdata = resp_rdata;
        bus.m0_err   = resp_err;
        bus.m1_err   = resp_err;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized transaction-level bench for bus_arbiter
// with a per-cycle compare process and literal pins on directed scenarios.
module tb_bus_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    bus_arbiter_if bus();

    bus_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit          pend [2];
    logic        rq_we [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wdata [2];
    logic [3:0]  rq_be [2];
    int          starve = 0;
    bit          rnd_mid = 0;

    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [3:0]  m_be = 4'd0;

    bit          chk_en = 0;
    logic        e_busy, e_sv, e_swe, e_ack0, e_ack1, e_err;
    logic [31:0] e_saddr, e_swd, e_rdata;
    logic [3:0]  e_sbe;

    int          cur_len = 0, cur_sv = 0, mon_len = 0, mon_sv = 0;
    logic [31:0] mon_rdata = 32'd0, mon_swd = 32'd0;
    logic        mon_err = 1'b0, mon_swe = 1'b0;
    logic [3:0]  mon_sbe = 4'd0;
    int          grants [$];
    int          exp37 [6] = '{0, 0, 0, 0, 1, 0};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {31'd0, busy}, {31'd0, e_busy});
            cmp("s_valid", {31'd0, bus.s_valid}, {31'd0, e_sv});
            cmp("s_byteen", {28'd0, bus.s_byteen}, {28'd0, e_sbe});
            cmp("s_we", {31'd0, bus.s_we}, {31'd0, e_swe});
            cmp("s_addr", bus.s_addr, e_saddr);
            cmp("s_wdata", bus.s_wdata, e_swd);
            cmp("m0_ack", {31'd0, bus.m0_ack}, {31'd0, e_ack0});
            cmp("m1_ack", {31'd0, bus.m1_ack}, {31'd0, e_ack1});
            if (e_ack0) begin
                cmp("m0_rdata", bus.m0_rdata, e_rdata);
                cmp("m0_err", {31'd0, bus.m0_err}, {31'd0, e_err});
            end
            if (e_ack1) begin
                cmp("m1_rdata", bus.m1_rdata, e_rdata);
                cmp("m1_err", {31'd0, bus.m1_err}, {31'd0, e_err});
            end
        end
        if (!reset) begin
            cur_len = 0;
            cur_sv  = 0;
        end else begin
            if (busy) cur_len++;
            if (bus.s_valid) begin
                cur_sv++;
                mon_sbe = bus.s_byteen;
                mon_swd = bus.s_wdata;
                mon_swe = bus.s_we;
            end
            if (bus.m0_ack || bus.m1_ack) begin
                grants.push_back(bus.m1_ack ? 1 : 0);
                mon_rdata = bus.m1_ack ? bus.m1_rdata : bus.m0_rdata;
                mon_err   = bus.m1_ack ? bus.m1_err : bus.m0_err;
                mon_len   = cur_len;
                mon_sv    = cur_sv;
                cur_len   = 0;
                cur_sv    = 0;
            end
        end
    end

    function automatic bit is_legal(input logic [31:0] a);
        logic [31:0] base [4];
        logic [31:0] size [4];
        base[0] = 32'h0;    size[0] = 32'h3000;
        base[1] = 32'h7F00; size[1] = 32'd12;
        base[2] = 32'h7F10; size[2] = 32'd12;
        base[3] = 32'h7F20; size[3] = 32'd4;
        for (int i = 0; i < 4; i++)
            if (a >= base[i] && (a - base[i]) < size[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [12];
        int r;
        edges[0] = 32'h2FFF; edges[1] = 32'h3000; edges[2] = 32'h7EFF;  edges[3] = 32'h7F0B;
        edges[4] = 32'h7F0C; edges[5] = 32'h7F0F; edges[6] = 32'h7F1B;  edges[7] = 32'h7F1C;
        edges[8] = 32'h7F1F; edges[9] = 32'h7F23; edges[10] = 32'h7F24; edges[11] = 32'h0;
        r = $urandom_range(0, 7);
        case (r)
            0: return 32'($urandom_range(0, 32'h2FFF));
            1: return 32'h7F00 + 32'($urandom_range(0, 11));
            2: return 32'h7F10 + 32'($urandom_range(0, 11));
            3: return 32'h7F20 + 32'($urandom_range(0, 3));
            4, 5: return edges[$urandom_range(0, 11)];
            default: return $urandom;
        endcase
    endfunction

    function automatic int rand_d();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(1, 4);
        if (r < 9) return $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
        return $urandom_range(1, TIMEOUT);
    endfunction

    task automatic drive();
        bus.m0_req = pend[0]; bus.m0_we = rq_we[0]; bus.m0_addr = rq_addr[0];
        bus.m0_wdata = rq_wdata[0]; bus.m0_byteen = rq_be[0];
        bus.m1_req = pend[1]; bus.m1_we = rq_we[1]; bus.m1_addr = rq_addr[1];
        bus.m1_wdata = rq_wdata[1]; bus.m1_byteen = rq_be[1];
    endtask

    task automatic raise(input int m, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        pend[m] = 1'b1; rq_we[m] = we; rq_addr[m] = a; rq_wdata[m] = wd; rq_be[m] = be;
        drive();
    endtask

    task automatic scramble(input int m);
        rq_we[m] = 1'($urandom_range(0, 1)); rq_addr[m] = $urandom;
        rq_wdata[m] = $urandom; rq_be[m] = 4'($urandom_range(0, 15));
        drive();
    endtask

    task automatic mid_raise(input int w);
        int o;
        o = 1 - w;
        if (!pend[o]) begin
            if ($urandom_range(0, 3) == 0)
                raise(o, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            else
                scramble(o);
        end
    endtask

    task automatic noise();
        bus.s_ready = 1'($urandom_range(0, 1));
        bus.s_rdata = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_busy = 0; e_sv = 0; e_sbe = 4'd0; e_ack0 = 0; e_ack1 = 0;
        e_swe = m_we; e_saddr = m_addr; e_swd = m_wdata;
    endtask

    task automatic set_access();
        e_busy = 1; e_sv = 1; e_sbe = m_we ? m_be : 4'd0; e_ack0 = 0; e_ack1 = 0;
        e_swe = m_we; e_saddr = m_addr; e_swd = m_wdata;
    endtask

    task automatic set_resp(input int w, input logic [31:0] rd, input logic err);
        e_busy = 1; e_sv = 0; e_sbe = 4'd0;
        e_ack0 = (w == 0); e_ack1 = (w == 1); e_rdata = rd; e_err = err;
        e_swe = m_we; e_saddr = m_addr; e_swd = m_wdata;
    endtask

    // One arbitration round: d is the ACCESS cycle (1-based) in which the slave answers.
    task automatic run_txn(input int d, input logic [31:0] rdv);
        int w, nacc;
        bit legal;
        logic err;
        logic [31:0] rd;
        drive();
        set_idle();
        noise();
        if (!pend[0] && !pend[1]) begin
            tick();
            return;
        end
        w = (pend[0] && pend[1]) ? ((starve == STARVE_MAX) ? 1 : 0) : (pend[1] ? 1 : 0);
        if (w == 0 && pend[1]) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else starve = 0;
        m_we = rq_we[w]; m_addr = rq_addr[w]; m_wdata = rq_wdata[w]; m_be = rq_be[w];
        legal = is_legal(m_addr);
        tick();
        if (rnd_mid) scramble(w);
        if (legal) begin
            nacc = (d <= TIMEOUT) ? d : TIMEOUT;
            for (int k = 1; k <= nacc; k++) begin
                set_access();
                bus.s_ready = (k == d);
                bus.s_rdata = (k == d) ? rdv : $urandom;
                if (rnd_mid) mid_raise(w);
                tick();
            end
            err = (d > TIMEOUT);
            rd  = (err || m_we) ? 32'd0 : rdv;
        end else begin
            err = 1'b1;
            rd  = 32'd0;
        end
        set_resp(w, rd, err);
        noise();
        if (rnd_mid) mid_raise(w);
        tick();
        pend[w] = 1'b0;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n_before;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; rq_we[m] = 0; rq_addr[m] = 0; rq_wdata[m] = 0; rq_be[m] = 0;
        end
        drive();
        bus.s_ready = 0;
        bus.s_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_busy", {31'd0, busy}, 32'd0);
        cmp("rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
        cmp("rst_s_addr", bus.s_addr, 32'd0);
        cmp("rst_m0_ack", {31'd0, bus.m0_ack}, 32'd0);
        cmp("rst_m1_ack", {31'd0, bus.m1_ack}, 32'd0);
        cmp("rst_m0_rdata", bus.m0_rdata, 32'd0);
        reset = 1'b1;
        set_idle();
        chk_en = 1;
        run_txn(1, 32'd0);

        raise(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        run_txn(1, 32'hDEAD_BEEF);
        cmp("r35_owner", 32'(grants[$]), 32'd0);
        cmp("r35_rdata", mon_rdata, 32'hDEAD_BEEF);
        cmp("r35_err", {31'd0, mon_err}, 32'd0);
        cmp("r35_busy_len", 32'(mon_len), 32'd2);
        cmp("r35_s_byteen", {28'd0, mon_sbe}, 32'd0);

        raise(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
        run_txn(1, 32'hAAAA_5555);
        cmp("r36_owner", 32'(grants[$]), 32'd1);
        cmp("r36_s_we", {31'd0, mon_swe}, 32'd1);
        cmp("r36_s_byteen", {28'd0, mon_sbe}, 32'd3);
        cmp("r36_s_wdata", mon_swd, 32'h1234_5678);
        cmp("r36_err", {31'd0, mon_err}, 32'd0);

        grants.delete();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                if (!pend[0]) raise(0, 1'b0, 32'h0000_0400 + 32'(4 * i), 32'h0, 4'hF);
                if (!pend[1]) raise(1, 1'b0, 32'h0000_7F10, 32'h0, 4'hF);
            end
            run_txn(1, $urandom);
        end
        cmp("r37_count", 32'(grants.size()), 32'd7);
        for (int i = 0; i < 6; i++)
            if (i < grants.size()) cmp("r37_order", 32'(grants[i]), 32'(exp37[i]));

        raise(0, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
        run_txn(1, 32'h1111_1111);
        cmp("r38_err", {31'd0, mon_err}, 32'd1);
        cmp("r38_rdata", mon_rdata, 32'd0);
        cmp("r38_busy_len", 32'(mon_len), 32'd1);
        cmp("r38_s_valid_cycles", 32'(mon_sv), 32'd0);

        raise(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        run_txn(TIMEOUT + 5, 32'h2222_2222);
        cmp("r39_to_s_valid_cycles", 32'(mon_sv), 32'd15);
        cmp("r39_to_err", {31'd0, mon_err}, 32'd1);
        cmp("r39_to_rdata", mon_rdata, 32'd0);
        raise(0, 1'b0, 32'h0000_0304, 32'h0, 4'hF);
        run_txn(TIMEOUT, 32'hCAFE_F00D);
        cmp("r39_last_s_valid_cycles", 32'(mon_sv), 32'd15);
        cmp("r39_last_err", {31'd0, mon_err}, 32'd0);
        cmp("r39_last_rdata", mon_rdata, 32'hCAFE_F00D);

        raise(0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
        set_idle();
        bus.s_ready = 0;
        tick();
        chk_en = 0;
        cmp("r40_s_valid_pre", {31'd0, bus.s_valid}, 32'd1);
        n_before = grants.size();
        #2;
        reset = 1'b0;
        #1;
        cmp("r40_s_valid", {31'd0, bus.s_valid}, 32'd0);
        cmp("r40_busy", {31'd0, busy}, 32'd0);
        pend[0] = 0; pend[1] = 0;
        drive();
        starve = 0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        tick();
        set_idle();
        chk_en = 1;
        repeat (3) run_txn(1, 32'd0);
        cmp("r40_no_ack", 32'(grants.size()), 32'(n_before));
        raise(0, 1'b0, 32'h0000_7F04, 32'h0, 4'hF);
        run_txn(2, 32'h0BAD_CAFE);
        cmp("r40_after_rdata", mon_rdata, 32'h0BAD_CAFE);
        cmp("r40_after_busy_len", 32'(mon_len), 32'd3);

        rnd_mid = 1;
        repeat (400) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(0, 2) != 0)
                    raise(m, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                          4'($urandom_range(0, 15)));
            run_txn(rand_d(), $urandom);
        end
        rnd_mid = 0;
        for (int i = 0; i < 3; i++) run_txn(1, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
